// File: rtl/io_bus_target.sv
// Bus target on the multiplexed 16-bit AD bus: decodes a BASE window and exposes 2^AW registers.
// Optional protocol checker enabled by defining IO_BUS_TARGET_PROTO_CHK_EN (err tied 0 otherwise).
module io_bus_target #(
  parameter logic [19:0] BASE      = 20'hF0000,
  parameter int unsigned AW        = 3,
  parameter logic        PIO_SPACE = 1'b1
) (
  input  logic                       clk,
  input  logic                       rst_neg,
  input  logic [15:0]                ad_in,
  input  logic [3:0]                 adr_hi,
  input  logic                       ale_neg,
  input  logic                       oe,
  input  logic                       we,
  input  logic                       pio,
  input  logic                       isout,
  output logic [15:0]                ad_out,
  output logic                       ad_oe,
  input  logic                       hw_wr,
  input  logic [AW-1:0]              hw_idx,
  input  logic [15:0]                hw_data,
  output logic                       wr_pulse,
  output logic                       rd_pulse,
  output logic [AW-1:0]              ev_idx,
  output logic [16*(2**AW)-1:0]      regs_flat,
  output logic                       err
);

  localparam int unsigned NREG = 2**AW;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACT,
    ST_HOLD,
    ST_SKIP
  } state_t;

  state_t          state_q, state_d;
  logic            ale_q;
  logic [AW-1:0]   idx_q, idx_d;
  logic [15:0]     ad_out_q, ad_out_d;
  logic            wr_pulse_q, wr_pulse_d;
  logic            rd_pulse_q, rd_pulse_d;
  logic [AW-1:0]   ev_idx_q, ev_idx_d;
  logic [15:0]     regs_q [NREG];
  logic [15:0]     regs_d [NREG];

  logic [19:0]     addr;
  logic            hit;
  logic            addr_edge;

  assign addr      = {adr_hi, ad_in};
  assign hit       = (addr[19:AW] == BASE[19:AW]) && (pio == PIO_SPACE);
  assign addr_edge = ale_q & ~ale_neg;

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    ad_out_d   = ad_out_q;
    wr_pulse_d = 1'b0;
    rd_pulse_d = 1'b0;
    ev_idx_d   = ev_idx_q;
    regs_d     = regs_q;

    // Local write first so a same-index bus write on this edge overrides it.
    if (hw_wr) regs_d[hw_idx] = hw_data;

    case (state_q)
      ST_IDLE: begin
        if (addr_edge) begin
          if (hit) begin
            idx_d    = ad_in[AW-1:0];
            ad_out_d = regs_q[ad_in[AW-1:0]];
            state_d  = ST_ACT;
          end else begin
            state_d  = ST_SKIP;
          end
        end
      end
      ST_ACT: begin
        if (ale_neg) begin
          state_d = ST_IDLE;
        end else begin
          if (we) begin
            regs_d[idx_q] = ad_in;
            wr_pulse_d    = 1'b1;
            ev_idx_d      = idx_q;
          end else if (oe) begin
            rd_pulse_d    = 1'b1;
            ev_idx_d      = idx_q;
          end
          state_d = ST_HOLD;
        end
      end
      ST_HOLD, ST_SKIP: begin
        if (ale_neg) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_neg) begin
    if (!rst_neg) begin
      state_q    <= ST_IDLE;
      ale_q      <= 1'b1;
      idx_q      <= '0;
      ad_out_q   <= '0;
      wr_pulse_q <= 1'b0;
      rd_pulse_q <= 1'b0;
      ev_idx_q   <= '0;
      regs_q     <= '{default: '0};
    end else begin
      state_q    <= state_d;
      ale_q      <= ale_neg;
      idx_q      <= idx_d;
      ad_out_q   <= ad_out_d;
      wr_pulse_q <= wr_pulse_d;
      rd_pulse_q <= rd_pulse_d;
      ev_idx_q   <= ev_idx_d;
      regs_q     <= regs_d;
    end
  end

  assign ad_out   = ad_out_q;
  assign ad_oe    = (state_q == ST_ACT) & oe & ~we & ~isout;
  assign wr_pulse = wr_pulse_q;
  assign rd_pulse = rd_pulse_q;
  assign ev_idx   = ev_idx_q;

  for (genvar g = 0; g < NREG; g++) begin : g_flat
    assign regs_flat[g*16 +: 16] = regs_q[g];
  end

`ifdef IO_BUS_TARGET_PROTO_CHK_EN
  logic       err_q, err_d;
  logic [2:0] wait_cnt_q, wait_cnt_d;
  logic       waiting;

  assign waiting = (state_q == ST_HOLD) || (state_q == ST_SKIP);

  always_comb begin
    err_d      = err_q;
    wait_cnt_d = '0;
    // wait_cnt_q counts completed HOLD/SKIP cycles; a fifth cycle is a violation.
    if (waiting) wait_cnt_d = (wait_cnt_q == 3'd7) ? wait_cnt_q : wait_cnt_q + 3'd1;
    if (((state_q == ST_IDLE) || (state_q == ST_SKIP)) && ale_neg && we) err_d = 1'b1;
    if ((state_q == ST_ACT) && oe && !we && isout) err_d = 1'b1;
    if (waiting && (wait_cnt_q >= 3'd4)) err_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_neg) begin
    if (!rst_neg) begin
      err_q      <= 1'b0;
      wait_cnt_q <= '0;
    end else begin
      err_q      <= err_d;
      wait_cnt_q <= wait_cnt_d;
    end
  end

  assign err = err_q;
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_io_bus_target.sv
// Self-checking bench for io_bus_target: register model plus a read-data scoreboard queue.
module tb_io_bus_target;

  localparam logic [19:0] BASE = 20'hF0000;

  logic          clk = 1'b0;
  logic          rst_neg;
  logic [15:0]   ad_in;
  logic [3:0]    adr_hi;
  logic          ale_neg;
  logic          oe;
  logic          we;
  logic          pio;
  logic          isout;
  logic [15:0]   ad_out;
  logic          ad_oe;
  logic          hw_wr;
  logic [2:0]    hw_idx;
  logic [15:0]   hw_data;
  logic          wr_pulse;
  logic          rd_pulse;
  logic [2:0]    ev_idx;
  logic [127:0]  regs_flat;
  logic          err;

  int unsigned   n_checks = 0;
  int unsigned   n_errors = 0;
  logic [15:0]   mdl [8];
  logic [15:0]   rd_q [$];

  io_bus_target #(.BASE(BASE), .AW(3), .PIO_SPACE(1'b1)) dut (
    .clk(clk), .rst_neg(rst_neg), .ad_in(ad_in), .adr_hi(adr_hi), .ale_neg(ale_neg),
    .oe(oe), .we(we), .pio(pio), .isout(isout), .ad_out(ad_out), .ad_oe(ad_oe),
    .hw_wr(hw_wr), .hw_idx(hw_idx), .hw_data(hw_data), .wr_pulse(wr_pulse),
    .rd_pulse(rd_pulse), .ev_idx(ev_idx), .regs_flat(regs_flat), .err(err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [127:0] flat();
    logic [127:0] r;
    for (int i = 0; i < 8; i++) r[i*16 +: 16] = mdl[i];
    return r;
  endfunction

  function automatic logic is_hit(input logic [19:0] a, input logic p);
    return (a[19:3] == BASE[19:3]) && p;
  endfunction

  task automatic drive_addr(input logic [19:0] a, input logic p);
    @(negedge clk);
    check("idle_wr_pulse", wr_pulse, 0);
    check("idle_rd_pulse", rd_pulse, 0);
    ale_neg = 1'b0; adr_hi = a[19:16]; ad_in = a[15:0]; pio = p;
    isout = 1'b1; oe = 1'b0; we = 1'b0;
  endtask

  task automatic bus_write(input logic [19:0] a, input logic p, input logic [15:0] d,
                           input logic hen, input logic [2:0] hidx, input logic [15:0] hdat);
    logic h;
    h = is_hit(a, p);
    drive_addr(a, p);
    @(negedge clk);
    ad_in = d; we = 1'b1; hw_wr = hen; hw_idx = hidx; hw_data = hdat;
    if (hen) mdl[hidx] = hdat;
    if (h) mdl[a[2:0]] = d;
    #1 check("wr_ad_oe", ad_oe, 0);
    @(negedge clk);
    check("wr_pulse", wr_pulse, h);
    if (h) check("wr_ev_idx", ev_idx, a[2:0]);
    check("wr_regs", regs_flat, flat());
    check("wr_no_rd_pulse", rd_pulse, 0);
    hw_wr = 1'b0; we = 1'b0; ale_neg = 1'b1;
  endtask

  task automatic bus_read(input logic [19:0] a, input logic p, input logic hen, input logic [15:0] hdat);
    logic h;
    logic [15:0] exp;
    h = is_hit(a, p);
    drive_addr(a, p);
    if (h) rd_q.push_back(mdl[a[2:0]]);
    @(negedge clk);
    oe = 1'b1; we = 1'b0; isout = 1'b0; ad_in = 16'h0;
    hw_wr = hen; hw_idx = a[2:0]; hw_data = hdat;
    if (hen) mdl[a[2:0]] = hdat;
    #1 check("rd_ad_oe", ad_oe, h);
    if (h) begin
      exp = rd_q.pop_front();
      check("rd_ad_out", ad_out, exp);
    end
    @(negedge clk);
    hw_wr = 1'b0;
    check("rd_ad_oe_after", ad_oe, 0);
    check("rd_pulse", rd_pulse, h);
    if (h) check("rd_ev_idx", ev_idx, a[2:0]);
    check("rd_no_wr_pulse", wr_pulse, 0);
    check("rd_regs", regs_flat, flat());
    oe = 1'b0; isout = 1'b1; ale_neg = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst_neg = 1'b0; ad_in = '0; adr_hi = '0; ale_neg = 1'b1; oe = 1'b0; we = 1'b0;
    pio = 1'b0; isout = 1'b1; hw_wr = 1'b0; hw_idx = '0; hw_data = '0;
    for (int i = 0; i < 8; i++) mdl[i] = '0;
    @(negedge clk); @(negedge clk);
    check("rst_ad_oe", ad_oe, 0);
    check("rst_ad_out", ad_out, 0);
    check("rst_wr_pulse", wr_pulse, 0);
    check("rst_rd_pulse", rd_pulse, 0);
    check("rst_ev_idx", ev_idx, 0);
    check("rst_err", err, 0);
    check("rst_regs", regs_flat, 0);
    rst_neg = 1'b1;

    bus_write(20'hF0003, 1'b1, 16'hBEEF, 1'b0, 3'd0, 16'h0);
    check("beef_slice", regs_flat[63:48], 16'hBEEF);
    bus_read(20'hF0003, 1'b1, 1'b0, 16'h0);

    bus_write(20'hE0003, 1'b1, 16'hDEAD, 1'b0, 3'd0, 16'h0);
    bus_write(20'hF0001, 1'b0, 16'hCAFE, 1'b0, 3'd0, 16'h0);
    bus_read(20'hE0003, 1'b1, 1'b0, 16'h0);
    bus_read(20'hF0001, 1'b0, 1'b0, 16'h0);

    bus_write(20'hF0005, 1'b1, 16'h1234, 1'b1, 3'd5, 16'h5555);
    bus_read(20'hF0005, 1'b1, 1'b0, 16'h0);

    bus_write(20'hF0002, 1'b1, 16'h0F0F, 1'b1, 3'd6, 16'h6666);
    bus_read(20'hF0006, 1'b1, 1'b0, 16'h0);

    bus_read(20'hF0003, 1'b1, 1'b1, 16'h7777);
    bus_read(20'hF0003, 1'b1, 1'b0, 16'h0);

    for (int i = 0; i < 8; i++)
      bus_write(BASE | 20'(i), 1'b1, 16'(16'hA000 ^ (i * 16'h1111)), 1'b0, 3'd0, 16'h0);
    for (int i = 7; i >= 0; i--)
      bus_read(BASE | 20'(i), 1'b1, 1'b0, 16'h0);

    // Aborted cycle: ale_neg returns high during ACT with we asserted.
    drive_addr(20'hF0004, 1'b1);
    @(negedge clk);
    ale_neg = 1'b1; we = 1'b1; ad_in = 16'hFFFF;
    @(negedge clk);
    check("abort_wr_pulse", wr_pulse, 0);
    check("abort_regs", regs_flat, flat());
    we = 1'b0;
    check("err_clean", err, 0);

    // Reset during a read data cycle.
    drive_addr(20'hF0003, 1'b1);
    rd_q.push_back(mdl[3]);
    @(negedge clk);
    oe = 1'b1; isout = 1'b0;
    #1 check("pre_rst_ad_oe", ad_oe, 1);
    check("pre_rst_ad_out", ad_out, rd_q.pop_front());
    #1 rst_neg = 1'b0;
    #1 check("async_rst_ad_oe", ad_oe, 0);
    oe = 1'b0; isout = 1'b1; ale_neg = 1'b1;
    for (int i = 0; i < 8; i++) mdl[i] = '0;
    @(negedge clk);
    rst_neg = 1'b1;
    check("post_rst_regs", regs_flat, 0);
    check("post_rst_ad_out", ad_out, 0);
    check("post_rst_wr_pulse", wr_pulse, 0);
    bus_read(20'hF0003, 1'b1, 1'b0, 16'h0);

    // Write strobe outside a cycle.
    @(negedge clk);
    we = 1'b1;
    @(negedge clk);
    we = 1'b0;
    @(negedge clk);
`ifdef IO_BUS_TARGET_PROTO_CHK_EN
    check("err_set", err, 1);
`else
    check("err_set", err, 0);
`endif
    bus_write(20'hF0007, 1'b1, 16'h4321, 1'b0, 3'd0, 16'h0);
    bus_read(20'hF0007, 1'b1, 1'b0, 16'h0);
`ifdef IO_BUS_TARGET_PROTO_CHK_EN
    check("err_sticky", err, 1);
`else
    check("err_sticky", err, 0);
`endif
    check("sb_empty", rd_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/io_bus_target.md
Name: io_bus_target

Overview:
- Responder on the external multiplexed 16-bit address/data bus driven by the CPU bus master: ale_neg address phase, oe/we strobes, pio space select, isout master-drive flag.
- Decodes a BASE window and exposes a bank of 2^AW 16-bit registers to the CPU.
- Peripheral logic gets a local side: a hardware update port and one-cycle read/write event pulses.
- Instanced once per memory-mapped peripheral on the board-level bus.

Parameters:
- BASE, 20'hF0000, window base; hit when {adr_hi, ad_in}[19:AW] == BASE[19:AW].
- AW, 3, register index width; the bank holds 2^AW words, word-indexed by address[AW-1:0].
- PIO_SPACE, 1, value of pio required for a hit; 0 responds only when pio=0.

Ports:
- clk  in  1  bus clock, same clock as the bus master.
- rst_neg  in  1  asynchronous active-low reset.
- ad_in  in  16  AD lines: address in the address phase, write data in the data phase.
- adr_hi  in  4  address bits 19:16.
- ale_neg  in  1  low = address phase / cycle active.
- oe  in  1  bus strobe.
- we  in  1  write strobe.
- pio  in  1  IO-space select.
- isout  in  1  master is driving AD.
- ad_out  out  16  read data.
- ad_oe  out  1  target drives AD.
- hw_wr  in  1  local write enable.
- hw_idx  in  AW  local write index.
- hw_data  in  16  local write data.
- wr_pulse  out  1  one-cycle pulse after a committed bus write.
- rd_pulse  out  1  one-cycle pulse after a served bus read.
- ev_idx  out  AW  index for wr_pulse/rd_pulse.
- regs_flat  out  16*2^AW  register bank contents, index 0 in the LSBs.
- err  out  1  protocol error, sticky; see Optional Feature.

Behaviour:
- Reset values (asynchronous): state IDLE, ale_q=1, all registers 0, ad_out=0, ad_oe=0, wr_pulse=0, rd_pulse=0, ev_idx=0, err=0.
- Edge detect: ale_q <= ale_neg every clk. An address edge is a posedge with ale_q=1 and ale_neg=0.
- IDLE
  - On an address edge with a hit (window match and pio==PIO_SPACE): idx <= ad_in[AW-1:0]; ad_out <= reg[ad_in[AW-1:0]] (prefetch, read with the live address); go to ACT.
  - On an address edge with a miss: go to SKIP.
- ACT (one cycle; master data phase)
  - ad_oe = oe & ~we & ~isout, combinational from the registered state. Asserted only in ACT.
  - At the posedge ending ACT:
    - we=1: reg[idx] <= ad_in; wr_pulse=1; ev_idx=idx.
    - oe=1, we=0: rd_pulse=1; ev_idx=idx.
  - Always go to HOLD.
  - If ale_neg=1 during ACT (aborted cycle): no commit, no pulse; go to IDLE.
- HOLD / SKIP: wait for ale_neg=1, then go to IDLE.
  - Back-to-back cycles are required to work: ale_neg high for one cycle, then low again → a new address edge is detected from IDLE.
- Latency:
  - Address latched on the posedge where ale_neg is first sampled low.
  - Read data valid for the whole following cycle (ad_out is registered).
  - Write data sampled on the posedge where we is seen high in ACT.
  - Write visible in regs_flat on the next cycle.
- Read snapshot: ad_out is captured at the address edge. A hw_wr or bus write to the same index during ACT does not change the returned data.
- Collision: hw_wr and a bus write to the same index on the same edge → bus data wins. Different indices → both commit.
- wr_pulse/rd_pulse are high for exactly one cycle; never both in the same cycle.
- Reset asserted mid-cycle: ad_oe drops immediately (asynchronous); no partial write.

Optional Feature:
- Macro IO_BUS_TARGET_PROTO_CHK_EN.
- Defined:
  - err sets, and stays set until reset, when any of these occur:
    - we=1 while in IDLE or SKIP with ale_neg=1;
    - oe&~we while isout=1 during ACT;
    - HOLD/SKIP lasts more than 4 cycles.
  - A violating write is still committed.
- Undefined: err tied 0; no checker logic.

Test Plan:
- Write 16'hBEEF to address 20'hF0003, pio=1 → wr_pulse one cycle with ev_idx=3; regs_flat[63:48]=16'hBEEF the next cycle; ad_oe stays 0.
- Read 20'hF0003 after that write → ad_oe=1 for exactly the data cycle with ad_out=16'hBEEF; rd_pulse=1 one cycle, ev_idx=3.
- Miss address 20'hE0003, and address 20'hF0001 with pio=0 → ad_oe never 1; no pulses; bank unchanged.
- Back-to-back write 16'h1234 to idx 5 then read idx 5, with one ale_neg-high cycle between → read returns 16'h1234. Same-edge hw_wr idx 5 = 16'h5555 during the bus write → reg5=16'h1234.
- rst_neg low during a read data cycle → ad_oe=0 immediately; after release, state IDLE and all registers read 0.
- With IO_BUS_TARGET_PROTO_CHK_EN: we pulsed while ale_neg=1 → err=1 and stays 1 through later legal cycles. Without the macro: err=0.
